axon_event_queue: RTL and testbench

AXON_EVENT_QUEUE -- requirements
Module: axon_event_queue

---
 rtl/ranc_core_pkg.sv | 35 +++
 rtl/axon_event_bank.sv | 69 ++++++
 rtl/axon_event_queue.sv | 126 ++++++++++++
 tb/tb_axon_event_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ranc_core_pkg.sv
// ranc_core_pkg
//   Shared sizing helpers for the axon event queue:
//   - axon_w / tick_w : widths of the axon and tick-offset fields (AW, TW)
//   - count_w         : width of a per-bank occupancy count (0..DEPTH)
//   - din_tick_lsb / din_axon_lsb : bit offsets of the fields inside din,
//     laid out as {axon[AW-1:0], tick_offset[TW-1:0]}
package ranc_core_pkg;

  // $clog2 floored at 1 so degenerate sizes still yield a legal vector width.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int axon_w(input int num_axons);
    return clog2_min1(num_axons);
  endfunction

  function automatic int tick_w(input int num_ticks);
    return clog2_min1(num_ticks);
  endfunction

  // Needs one extra code point so a full bank (count == DEPTH) is representable.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int din_tick_lsb();
    return 0;
  endfunction

  function automatic int din_axon_lsb(input int tw);
    return tw;
  endfunction

endpackage

// File: rtl/axon_event_bank.sv
// axon_event_bank
//   One circular FIFO of DEPTH axon numbers for a single delivery tick.
//   The parent guarantees push never targets a full bank, pop never targets
//   an empty bank, and pop is never issued together with flush.
// Ports
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset (pointers and count)
//   i_push    write i_wdata at the tail
//   i_pop     advance the head (o_rdata is the head before the pop)
//   i_flush   discard all contents; a same-cycle push lands in the emptied bank
//   i_wdata   axon number to store
//   o_rdata   axon number at the head
//   o_count   number of stored entries
module axon_event_bank
  import ranc_core_pkg::*;
#(
  parameter  int AW    = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = count_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [AW-1:0] i_wdata,
  output logic [AW-1:0] o_rdata,
  output logic [CW-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_waddr;

  // A push in the flush cycle is written at slot 0, the start of the reset ring.
  assign w_waddr = i_flush ? '0 : r_wptr;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[w_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= i_push ? PW'(1) : '0;
      r_count <= i_push ? CW'(1) : '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/axon_event_queue.sv
// axon_event_queue
//   Tick-indexed spike event queue: NUM_TICKS banks, one per future delivery
//   tick. Pushes land in bank (cur_tick + tick_offset); pops drain the bank of
//   the current tick; a tick pulse advances cur_tick and discards whatever the
//   old bank still held (a late delivery).
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   din              {axon, tick_offset}
//   wr_en            push din
//   tick             advance current tick
//   rd_en            pop from the current-tick bank
//   dout, valid      popped axon, valid one cycle after the pop
//   wr_ack           previous-cycle push was stored
//   empty, full      current bank empty / any bank full
//   cur_tick         current tick index
//   overflow_error   sticky: a push was dropped on a full bank
//   late_error       sticky: tick arrived with the current bank non-empty
module axon_event_queue
  import ranc_core_pkg::*;
#(
  parameter  int NUM_AXONS = 256,
  parameter  int NUM_TICKS = 16,
  parameter  int DEPTH     = 16,
  localparam int AW        = axon_w(NUM_AXONS),
  localparam int TW        = tick_w(NUM_TICKS),
  localparam int CW        = count_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW+TW-1:0] din,
  input  logic          wr_en,
  input  logic          tick,
  input  logic          rd_en,
  output logic [AW-1:0] dout,
  output logic          valid,
  output logic          wr_ack,
  output logic          empty,
  output logic          full,
  output logic [TW-1:0] cur_tick,
  output logic          overflow_error,
  output logic          late_error
);

  localparam int TICK_LSB = din_tick_lsb();
  localparam int AXON_LSB = din_axon_lsb(TW);

  logic [TW-1:0]        r_cur_tick;
  logic [AW-1:0]        r_dout;
  logic                 r_valid;
  logic                 r_wr_ack;
  logic                 r_overflow;
  logic                 r_late;

  logic [TW-1:0]        w_tick_off;
  logic [AW-1:0]        w_axon;
  logic [TW-1:0]        w_tgt;
  logic [NUM_TICKS-1:0] w_bank_empty;
  logic [NUM_TICKS-1:0] w_bank_full;
  logic [NUM_TICKS-1:0] w_push;
  logic [NUM_TICKS-1:0] w_pop;
  logic [NUM_TICKS-1:0] w_flush;
  logic [AW-1:0]        w_rdata [NUM_TICKS];
  logic [CW-1:0]        w_count [NUM_TICKS];
  logic                 w_cur_empty;
  logic                 w_drop;

  assign w_tick_off = din[TICK_LSB +: TW];
  assign w_axon     = din[AXON_LSB +: AW];
  // NUM_TICKS is a power of two, so the TW-bit add wraps modulo NUM_TICKS.
  assign w_tgt      = r_cur_tick + w_tick_off;

  for (genvar b = 0; b < NUM_TICKS; b++) begin : g_bank
    assign w_bank_empty[b] = (w_count[b] == '0);
    assign w_bank_full[b]  = (w_count[b] == CW'(DEPTH));
    assign w_push[b]       = wr_en && (w_tgt == TW'(b)) && !w_bank_full[b];
    assign w_flush[b]      = tick && (r_cur_tick == TW'(b));
    // Popping is suppressed in a tick cycle; the bank is being flushed instead.
    assign w_pop[b]        = rd_en && !tick && (r_cur_tick == TW'(b)) && !w_bank_empty[b];

    axon_event_bank #(
      .AW    (AW),
      .DEPTH (DEPTH)
    ) u_bank (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_push  (w_push[b]),
      .i_pop   (w_pop[b]),
      .i_flush (w_flush[b]),
      .i_wdata (w_axon),
      .o_rdata (w_rdata[b]),
      .o_count (w_count[b])
    );
  end

  assign w_cur_empty = w_bank_empty[r_cur_tick];
  // Fullness is judged before any same-cycle pop, so a push to a full bank drops.
  assign w_drop      = wr_en && w_bank_full[w_tgt];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_tick <= '0;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_overflow <= 1'b0;
      r_late     <= 1'b0;
    end else begin
      if (tick) r_cur_tick <= r_cur_tick + TW'(1);
      r_valid  <= |w_pop;
      if (|w_pop) r_dout <= w_rdata[r_cur_tick];
      r_wr_ack <= |w_push;
      if (w_drop) r_overflow <= 1'b1;
      if (tick && !w_cur_empty) r_late <= 1'b1;
    end
  end

  assign dout           = r_dout;
  assign valid          = r_valid;
  assign wr_ack         = r_wr_ack;
  assign cur_tick       = r_cur_tick;
  assign overflow_error = r_overflow;
  assign late_error     = r_late;
  assign empty          = w_cur_empty;
  assign full           = |w_bank_full;

endmodule

// File: tb/tb_axon_event_queue.sv
module tb_axon_event_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] din;
  logic        wr_en, tick, rd_en;
  logic [7:0]  dout;
  logic        valid, wr_ack, empty, full;
  logic [3:0]  cur_tick;
  logic        overflow_error, late_error;

  int checks   = 0;
  int failures = 0;
  int ack_cnt;

  axon_event_queue #(.NUM_AXONS(256), .NUM_TICKS(16), .DEPTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .din            (din),
    .wr_en          (wr_en),
    .tick           (tick),
    .rd_en          (rd_en),
    .dout           (dout),
    .valid          (valid),
    .wr_ack         (wr_ack),
    .empty          (empty),
    .full           (full),
    .cur_tick       (cur_tick),
    .overflow_error (overflow_error),
    .late_error     (late_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       tk;
    logic       rd;
    logic [7:0] axon;
    logic [3:0] off;
    logic       e_valid;
    logic [7:0] e_dout;
    logic       e_ack;
    logic       e_empty;
    logic       e_full;
    logic [3:0] e_cur;
    logic       e_ovf;
    logic       e_late;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic t, input logic r,
                       input logic [7:0] axon, input logic [3:0] off);
    wr_en = w;
    tick  = t;
    rd_en = r;
    din   = {axon, off};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b1, 1'b0, 8'd0, 4'd0);
      cyc();
    end
    idle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " cur_tick"}, 32'(cur_tick), 0);
    chk({tag, " dout"},     32'(dout), 0);
    chk({tag, " valid"},    32'(valid), 0);
    chk({tag, " wr_ack"},   32'(wr_ack), 0);
    chk({tag, " empty"},    32'(empty), 1);
    chk({tag, " full"},     32'(full), 0);
    chk({tag, " ovf"},      32'(overflow_error), 0);
    chk({tag, " late"},     32'(late_error), 0);
  endtask

  initial begin
    vt[0] = '{1'b1,1'b0,1'b0,8'd5,4'd0, 1'b0,8'd0,1'b1,1'b0,1'b0,4'd0,1'b0,1'b0};
    vt[1] = '{1'b0,1'b0,1'b1,8'd0,4'd0, 1'b1,8'd5,1'b0,1'b1,1'b0,4'd0,1'b0,1'b0};
    vt[2] = '{1'b0,1'b0,1'b1,8'd0,4'd0, 1'b0,8'd5,1'b0,1'b1,1'b0,4'd0,1'b0,1'b0};
    vt[3] = '{1'b1,1'b0,1'b1,8'd7,4'd1, 1'b0,8'd5,1'b1,1'b1,1'b0,4'd0,1'b0,1'b0};
    vt[4] = '{1'b0,1'b1,1'b0,8'd0,4'd0, 1'b0,8'd5,1'b0,1'b0,1'b0,4'd1,1'b0,1'b0};
    vt[5] = '{1'b0,1'b0,1'b1,8'd0,4'd0, 1'b1,8'd7,1'b0,1'b1,1'b0,4'd1,1'b0,1'b0};
    vt[6] = '{1'b1,1'b0,1'b1,8'd3,4'd0, 1'b0,8'd7,1'b1,1'b0,1'b0,4'd1,1'b0,1'b0};
    vt[7] = '{1'b1,1'b0,1'b1,8'd4,4'd0, 1'b1,8'd3,1'b1,1'b0,1'b0,4'd1,1'b0,1'b0};
    vt[8] = '{1'b0,1'b1,1'b1,8'd0,4'd0, 1'b0,8'd3,1'b0,1'b1,1'b0,4'd2,1'b0,1'b1};
    vt[9] = '{1'b0,1'b0,1'b0,8'd0,4'd0, 1'b0,8'd3,1'b0,1'b1,1'b0,4'd2,1'b0,1'b1};

    // Reset values while rst is held low
    idle();
    rst = 1'b0;
    repeat (2) cyc();
    chk_reset_vals("rst");
    rst = 1'b1;

    // Table: basic push/pop, underflow, routing, same-cycle push+pop, tick flush
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].wr, vt[i].tk, vt[i].rd, vt[i].axon, vt[i].off);
      cyc();
      chk($sformatf("v%0d valid", i),  32'(valid),          32'(vt[i].e_valid));
      chk($sformatf("v%0d dout", i),   32'(dout),           32'(vt[i].e_dout));
      chk($sformatf("v%0d wr_ack", i), 32'(wr_ack),         32'(vt[i].e_ack));
      chk($sformatf("v%0d empty", i),  32'(empty),          32'(vt[i].e_empty));
      chk($sformatf("v%0d full", i),   32'(full),           32'(vt[i].e_full));
      chk($sformatf("v%0d cur", i),    32'(cur_tick),       32'(vt[i].e_cur));
      chk($sformatf("v%0d ovf", i),    32'(overflow_error), 32'(vt[i].e_ovf));
      chk($sformatf("v%0d late", i),   32'(late_error),     32'(vt[i].e_late));
    end
    idle();

    // Wrap-around routing: cur_tick 15 + offset 3 -> bank 2
    do_reset();
    ticks(15);
    chk("wrap cur15", 32'(cur_tick), 15);
    drive(1'b1, 1'b0, 1'b0, 8'd9, 4'd3);
    cyc();
    chk("wrap ack", 32'(wr_ack), 1);
    chk("wrap empty15", 32'(empty), 1);
    idle();
    ticks(3);
    chk("wrap cur2", 32'(cur_tick), 2);
    chk("wrap empty2", 32'(empty), 0);
    chk("wrap late", 32'(late_error), 0);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    cyc();
    chk("wrap valid", 32'(valid), 1);
    chk("wrap dout", 32'(dout), 9);
    chk("wrap empty after", 32'(empty), 1);
    idle();

    // Overflow: 17 pushes to bank 1
    do_reset();
    ack_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(10 + i), 4'd1);
      cyc();
      ack_cnt += int'(wr_ack);
      if (i == 15) begin
        chk("ovf full16", 32'(full), 1);
        chk("ovf not yet", 32'(overflow_error), 0);
      end
    end
    idle();
    chk("ovf ack count", 32'(ack_cnt), 16);
    chk("ovf last ack", 32'(wr_ack), 0);
    chk("ovf flag", 32'(overflow_error), 1);
    chk("ovf full", 32'(full), 1);
    chk("ovf cur empty", 32'(empty), 1);
    ticks(1);
    chk("ovf cur1", 32'(cur_tick), 1);
    chk("ovf empty1", 32'(empty), 0);
    chk("ovf late", 32'(late_error), 0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
      cyc();
      chk($sformatf("ovf pop%0d valid", i), 32'(valid), 1);
      chk($sformatf("ovf pop%0d dout", i), 32'(dout), 32'(10 + i));
    end
    chk("ovf drained empty", 32'(empty), 1);
    chk("ovf drained full", 32'(full), 0);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    cyc();
    chk("ovf underflow valid", 32'(valid), 0);
    idle();

    // Late tick flushes a non-empty bank
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'd1, 4'd0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 8'd2, 4'd0);
    cyc();
    chk("late pre empty", 32'(empty), 0);
    ticks(1);
    chk("late cur1", 32'(cur_tick), 1);
    chk("late flag", 32'(late_error), 1);
    ticks(15);
    chk("late back cur0", 32'(cur_tick), 0);
    chk("late bank0 flushed", 32'(empty), 1);

    // Push into the current bank in the tick cycle survives the flush
    drive(1'b1, 1'b1, 1'b0, 8'd40, 4'd0);
    cyc();
    chk("survive ack", 32'(wr_ack), 1);
    chk("survive cur1", 32'(cur_tick), 1);
    idle();
    ticks(15);
    chk("survive cur0", 32'(cur_tick), 0);
    chk("survive empty", 32'(empty), 0);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    cyc();
    chk("survive valid", 32'(valid), 1);
    chk("survive dout", 32'(dout), 40);
    chk("survive late sticky", 32'(late_error), 1);
    idle();

    // Full bank: push+pop same cycle -> pop ok, push dropped, count 15
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(100 + i), 4'd0);
      cyc();
    end
    chk("fpp full", 32'(full), 1);
    chk("fpp empty", 32'(empty), 0);
    drive(1'b1, 1'b0, 1'b1, 8'd200, 4'd0);
    cyc();
    chk("fpp valid", 32'(valid), 1);
    chk("fpp dout", 32'(dout), 100);
    chk("fpp ack", 32'(wr_ack), 0);
    chk("fpp ovf", 32'(overflow_error), 1);
    chk("fpp full after", 32'(full), 0);
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
      cyc();
      chk($sformatf("fpp pop%0d", i), 32'(dout), 32'(100 + i));
    end
    chk("fpp drained", 32'(empty), 1);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    cyc();
    chk("fpp no 16th", 32'(valid), 0);
    idle();

    // Asynchronous reset mid-burst
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(50 + i), 4'd0);
      cyc();
    end
    chk("arst pre empty", 32'(empty), 0);
    drive(1'b1, 1'b0, 1'b1, 8'd60, 4'd0);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("arst");
    idle();
    cyc();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    cyc();
    chk("arst pop valid", 32'(valid), 0);
    chk("arst pop empty", 32'(empty), 1);
    chk("arst pop dout", 32'(dout), 0);
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
